// File: rtl/matvec_out_packer.sv
// Output stage for the matvec y-element stream: optional rounding shift, saturation to OUT_W,
// vector index/last tagging, and a small FIFO that absorbs short consumer backpressure.
module matvec_out_packer #(
   parameter int IN_W    = 28,
   parameter int OUT_W   = 16,
   parameter int VEC_LEN = 3,
   parameter int DEPTH   = 4,
   parameter int SHIFT   = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic [1:0]              out_idx,
   output logic                    out_last,
   output logic                    out_sat,
   output logic [15:0]             sat_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [1:0]  LAST_IDX = 2'(VEC_LEN - 1);
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [IN_W:0] RND  = (IN_W + 1)'(1) << RSH;
   localparam logic signed [IN_W:0] MAXV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [IN_W:0] MINV = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic signed [OUT_W-1:0] mem_data [DEPTH];
   logic [1:0]              mem_idx  [DEPTH];
   logic                    mem_sat  [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [1:0]    idx_cnt;

   logic signed [IN_W:0]    ext, r;
   logic signed [OUT_W-1:0] sat_data;
   logic                    sat_flag;
   logic                    push, pop;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // Extra headroom bit keeps the rounding add from overflowing at the top of the input range.
   always_comb begin
      ext      = {in_data[IN_W-1], in_data};
      r        = ext;
      sat_data = '0;
      sat_flag = 1'b0;
      if (SHIFT > 0) begin
         r = (ext + RND) >>> SHIFT;
      end
      if (r > MAXV) begin
         sat_data = {1'b0, {(OUT_W - 1){1'b1}}};
         sat_flag = 1'b1;
      end else if (r < MINV) begin
         sat_data = {1'b1, {(OUT_W - 1){1'b0}}};
         sat_flag = 1'b1;
      end else begin
         sat_data = r[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         idx_cnt   <= '0;
         sat_count <= '0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            idx_cnt <= (idx_cnt == LAST_IDX) ? 2'd0 : idx_cnt + 2'd1;
            if (sat_flag && (sat_count != '1)) begin
               sat_count <= sat_count + 16'd1;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage is left unreset; the outputs are gated by out_valid instead.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= sat_data;
         mem_idx[wr_ptr]  <= idx_cnt;
         mem_sat[wr_ptr]  <= sat_flag;
      end
   end

   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
   assign out_idx   = out_valid ? mem_idx[rd_ptr] : 2'd0;
   assign out_sat   = out_valid && mem_sat[rd_ptr];
   assign out_last  = out_valid && (mem_idx[rd_ptr] == LAST_IDX);

endmodule
